// File: rtl/m_memarb_if.sv
// ============================================================================
// Module : m_memarb_if
// Brief  : Fetch/data request ports and shared-RAM bus for the memory arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface m_memarb_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  // Fetch port
  logic              w_ireq;
  logic [ADDR_W-1:0] w_iaddr;
  logic              w_igrant;
  logic              r_ivalid;
  logic [DATA_W-1:0] w_idata;
  // Data port
  logic              w_dreq;
  logic              w_dwe;
  logic [ADDR_W-1:0] w_daddr;
  logic [DATA_W-1:0] w_ddin;
  logic              w_dgrant;
  logic              r_dvalid;
  logic [DATA_W-1:0] w_ddata;
  // Shared RAM
  logic [ADDR_W-1:0] w_maddr;
  logic              w_mwe;
  logic [DATA_W-1:0] w_mdin;
  logic [DATA_W-1:0] w_mdout;
  // Debug
  logic [CNT_W-1:0]  r_conflict;

  modport slave (
    input  w_ireq, w_iaddr, w_dreq, w_dwe, w_daddr, w_ddin, w_mdout,
    output w_igrant, r_ivalid, w_idata, w_dgrant, r_dvalid, w_ddata,
    output w_maddr, w_mwe, w_mdin, r_conflict
  );

  modport master (
    output w_ireq, w_iaddr, w_dreq, w_dwe, w_daddr, w_ddin, w_mdout,
    input  w_igrant, r_ivalid, w_idata, w_dgrant, r_dvalid, w_ddata,
    input  w_maddr, w_mwe, w_mdin, r_conflict
  );
endinterface

`default_nettype wire

// File: rtl/m_memarb.sv
// ============================================================================
// Module : m_memarb
// Brief  : Data-priority arbiter sharing one sync RAM between fetch and data
//          ports, with fetch starvation guard and contention counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module m_memarb #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 16
) (
  input  wire logic w_clk,
  input  wire logic w_rst,
  m_memarb_if.slave bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] C_STARVE_MAX = SW'(STARVE_MAX);
  localparam logic [0:0]    S_DPRI = 1'b0;
  localparam logic [0:0]    S_IPRI = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [SW-1:0]     r_starve;
  logic [SW-1:0]     w_starve_nxt;
  logic [SW-1:0]     w_starve_inc;
  logic              w_both;
  logic              w_igrant;
  logic              w_dgrant;
  logic              r_ivalid;
  logic              r_dvalid;
  logic [DATA_W-1:0] r_ihold;
  logic [DATA_W-1:0] r_dhold;
  logic [CNT_W-1:0]  r_conflict;

  assign w_both       = bus.w_ireq & bus.w_dreq;
  assign w_starve_inc = r_starve + SW'(1);

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_state  <= S_DPRI;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  // Starve counts only cycles where fetch is denied; any fetch grant or idle fetch clears it.
  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve;
    case (r_state)
      S_DPRI: begin
        if (w_both) begin
          w_starve_nxt = w_starve_inc;
          if (w_starve_inc >= C_STARVE_MAX) begin
            w_state_nxt = S_IPRI;
          end
        end else begin
          w_starve_nxt = '0;
        end
      end
      S_IPRI: begin
        w_state_nxt  = S_DPRI;
        w_starve_nxt = '0;
      end
      default: begin
        w_state_nxt  = S_DPRI;
        w_starve_nxt = '0;
      end
    endcase
  end

  always_comb begin
    w_igrant = 1'b0;
    w_dgrant = 1'b0;
    if (!w_rst) begin
      if (w_both) begin
        w_igrant = (r_state == S_IPRI);
        w_dgrant = (r_state != S_IPRI);
      end else begin
        w_igrant = bus.w_ireq;
        w_dgrant = bus.w_dreq;
      end
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_ivalid   <= 1'b0;
      r_dvalid   <= 1'b0;
      r_ihold    <= '0;
      r_dhold    <= '0;
      r_conflict <= '0;
    end else begin
      r_ivalid <= w_igrant;
      r_dvalid <= w_dgrant & ~bus.w_dwe;
      if (r_ivalid) begin
        r_ihold <= bus.w_mdout;
      end
      if (r_dvalid) begin
        r_dhold <= bus.w_mdout;
      end
      if (w_both && (r_conflict != {CNT_W{1'b1}})) begin
        r_conflict <= r_conflict + CNT_W'(1);
      end
    end
  end

  assign bus.w_igrant   = w_igrant;
  assign bus.w_dgrant   = w_dgrant;
  assign bus.w_maddr    = w_dgrant ? bus.w_daddr : bus.w_iaddr;
  assign bus.w_mwe      = w_dgrant & bus.w_dwe;
  assign bus.w_mdin     = bus.w_ddin;
  assign bus.r_ivalid   = r_ivalid;
  assign bus.r_dvalid   = r_dvalid;
  assign bus.w_idata    = r_ivalid ? bus.w_mdout : r_ihold;
  assign bus.w_ddata    = r_dvalid ? bus.w_mdout : r_dhold;
  assign bus.r_conflict = r_conflict;

endmodule

`default_nettype wire
